demux_1x16: RTL and testbench



---
 rtl/mycpu_pkg.sv | 13 +
 rtl/demux_slot.sv | 39 +++
 rtl/demux_1x16.sv | 107 ++++++++++
 tb/tb_demux_1x16.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared datapath types for the mycpu distribution/selection blocks.
package mycpu_pkg;

  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_sel_t;

endpackage : mycpu_pkg

// File: rtl/demux_slot.sv
// One-entry holding register with valid/ready drain; can_accept permits same-cycle drain and refill.
module demux_slot
  import mycpu_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] d,
  input  logic         rd_ready,
  output logic         valid,
  output logic [W-1:0] q,
  output logic         can_accept
);

  logic         valid_r;
  logic [W-1:0] q_r;

  // Slot state: a write always wins over a drain; the word is kept after a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      q_r     <= {W{1'b0}};
    end else if (wr) begin
      valid_r <= 1'b1;
      q_r     <= d;
    end else if (valid_r && rd_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid      = valid_r;
  assign q          = q_r;
  assign can_accept = !valid_r || rd_ready;

endmodule : demux_slot

// File: rtl/demux_1x16.sv
// Registered 1-to-2 demultiplexer for datapath words, with per-port accept counters.
module demux_1x16
  import mycpu_pkg::*;
#(
  parameter int DATA_W = mycpu_pkg::DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic              sel_in,
  input  logic [DATA_W-1:0] d_in,
  output logic              valid0_out,
  input  logic              ready0_in,
  output logic [DATA_W-1:0] d0_out,
  output logic              valid1_out,
  input  logic              ready1_in,
  output logic [DATA_W-1:0] d1_out,
  input  logic              clear_in,
  output logic [CNT_W-1:0]  cnt0_out,
  output logic [CNT_W-1:0]  cnt1_out
);

  port_sel_t        sel_s;
  logic             can0_s;
  logic             can1_s;
  logic             ready_s;
  logic             wr0_s;
  logic             wr1_s;
  logic [CNT_W-1:0] cnt0_r;
  logic [CNT_W-1:0] cnt1_r;

  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic clr);
    logic [CNT_W-1:0] res;
    if (clr) begin
      res = inc ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
    end else if (inc) begin
      res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  assign sel_s = port_sel_t'(sel_in);

  // Readiness follows the selected slot only; an unknown select falls to default so nothing is accepted.
  always_comb begin
    ready_s = 1'b0;
    wr0_s   = 1'b0;
    wr1_s   = 1'b0;
    case (sel_s)
      PORT0: begin
        ready_s = can0_s;
        wr0_s   = valid_in && can0_s;
      end
      PORT1: begin
        ready_s = can1_s;
        wr1_s   = valid_in && can1_s;
      end
      default: begin
        ready_s = 1'b0;
      end
    endcase
  end

  assign ready_out = ready_s;

  demux_slot #(.W(DATA_W)) u_slot0 (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr0_s),
    .d          (d_in),
    .rd_ready   (ready0_in),
    .valid      (valid0_out),
    .q          (d0_out),
    .can_accept (can0_s)
  );

  demux_slot #(.W(DATA_W)) u_slot1 (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr1_s),
    .d          (d_in),
    .rd_ready   (ready1_in),
    .valid      (valid1_out),
    .q          (d1_out),
    .can_accept (can1_s)
  );

  // Accept counters wrap silently; a clear coinciding with an accept leaves that port at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_r <= {CNT_W{1'b0}};
      cnt1_r <= {CNT_W{1'b0}};
    end else begin
      cnt0_r <= next_cnt(cnt0_r, wr0_s, clear_in);
      cnt1_r <= next_cnt(cnt1_r, wr1_s, clear_in);
    end
  end

  assign cnt0_out = cnt0_r;
  assign cnt1_out = cnt1_r;

endmodule : demux_1x16

// File: tb/tb_demux_1x16.sv
// Self-checking bench for demux_1x16: directed scenarios plus random traffic against a slot/counter model.
module tb_demux_1x16;
  import mycpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        ready_out;
  logic        sel_in;
  word_t       d_in;
  logic        valid0_out;
  logic        ready0_in;
  word_t       d0_out;
  logic        valid1_out;
  logic        ready1_in;
  word_t       d1_out;
  logic        clear_in;
  logic [7:0]  cnt0_out;
  logic [7:0]  cnt1_out;

  int tests = 0;
  int fails = 0;

  bit    m_full [2];
  word_t m_data [2];
  int    m_cnt  [2];

  demux_1x16 #(.DATA_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out), .sel_in(sel_in),
    .d_in(d_in), .valid0_out(valid0_out), .ready0_in(ready0_in), .d0_out(d0_out),
    .valid1_out(valid1_out), .ready1_in(ready1_in), .d1_out(d1_out),
    .clear_in(clear_in), .cnt0_out(cnt0_out), .cnt1_out(cnt1_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input bit s, input word_t d, input bit r0, input bit r1, input bit clr);
    valid_in  = v;
    sel_in    = s;
    d_in      = d;
    ready0_in = r0;
    ready1_in = r1;
    clear_in  = clr;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = 16'h0000;
      m_cnt[k]  = 0;
    end
  endtask

  task automatic chk_outputs(input string where);
    chk({where, ".valid0"}, valid0_out, m_full[0]);
    chk({where, ".valid1"}, valid1_out, m_full[1]);
    chk({where, ".d0"}, d0_out, m_data[0]);
    chk({where, ".d1"}, d1_out, m_data[1]);
    chk({where, ".cnt0"}, cnt0_out, m_cnt[0]);
    chk({where, ".cnt1"}, cnt1_out, m_cnt[1]);
  endtask

  // One clock cycle, entered just after a falling edge with inputs already driven.
  task automatic cycle(input string where, output bit accepted);
    bit    sel, v, clr, exp_rdy;
    bit    rdy [2];
    word_t d;
    sel = sel_in; v = valid_in; clr = clear_in; d = d_in;
    rdy[0] = ready0_in; rdy[1] = ready1_in;
    exp_rdy = !m_full[sel] || rdy[sel];
    #1;
    chk({where, ".ready_out"}, ready_out, exp_rdy);
    accepted = v && exp_rdy;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      bit acc_k;
      acc_k = accepted && (int'(sel) == k);
      if (acc_k) begin
        m_full[k] = 1'b1;
        m_data[k] = d;
      end else if (m_full[k] && rdy[k]) begin
        m_full[k] = 1'b0;
      end
      m_cnt[k] = clr ? int'(acc_k) : (m_cnt[k] + int'(acc_k)) % 256;
    end
    #1;
    chk_outputs(where);
    @(negedge clk);
  endtask

  initial begin
    bit acc;
    bit hold;
    model_reset();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_outputs("reset");
    rst = 1'b0;

    // Single transfer to port 1, then stalled port 1 blocks its select.
    drive(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    cycle("single", acc);
    chk("single.d1", d1_out, 32'h1234);
    drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle("single_blocked", acc);
    chk("single_blocked.ready", ready_out, 32'h0);

    // Port 1 stalled does not block port 0.
    drive(1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    cycle("isolate", acc);
    chk("isolate.d0", d0_out, 32'hBEEF);
    chk("isolate.d1", d1_out, 32'h1234);

    // Full throughput on port 0 after a counter clear.
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    cycle("clear", acc);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, word_t'(i), 1'b1, 1'b0, 1'b0);
      cycle("thru", acc);
      chk("thru.accepted", acc, 32'h1);
      chk("thru.d0", d0_out, i);
    end
    chk("thru.cnt0", cnt0_out, 32'd8);

    // Simultaneous drain with a refill of port 0.
    drive(1'b1, 1'b0, 16'hC0DE, 1'b1, 1'b1, 1'b0);
    cycle("simdrain", acc);
    chk("simdrain.v1", valid1_out, 32'h0);
    chk("simdrain.d0", d0_out, 32'hC0DE);

    // Counter wrap after 256 port-0 accepts, then clear with a same-cycle port-1 accept.
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    cycle("wrap_clear", acc);
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b0, word_t'($urandom), 1'b1, 1'b1, 1'b0);
      cycle("wrap", acc);
    end
    chk("wrap.cnt0", cnt0_out, 32'd0);
    drive(1'b1, 1'b1, 16'h7777, 1'b1, 1'b1, 1'b1);
    cycle("clr_acc", acc);
    chk("clr_acc.cnt1", cnt1_out, 32'd1);
    chk("clr_acc.cnt0", cnt0_out, 32'd0);

    // Randomized traffic; a stalled word is held stable until accepted.
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (hold) begin
        ready0_in = ($urandom_range(0, 3) != 0);
        ready1_in = ($urandom_range(0, 3) != 0);
        clear_in  = ($urandom_range(0, 31) == 0);
      end else begin
        drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), word_t'($urandom),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 31) == 0));
      end
      cycle("rand", acc);
      hold = valid_in && !acc;
    end

    // Reset mid-stream with both slots full is immediate.
    drive(1'b1, 1'b0, 16'hAAAA, 1'b0, 1'b0, 1'b0);
    cycle("pre_rst0", acc);
    while (m_full[0] && !acc) begin
      ready0_in = 1'b1;
      cycle("pre_rst0_drain", acc);
      ready0_in = 1'b0;
    end
    drive(1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
    cycle("pre_rst1", acc);
    while (!acc) begin
      ready1_in = 1'b1;
      cycle("pre_rst1_drain", acc);
      ready1_in = 1'b0;
    end
    chk("pre_rst.d0", d0_out, 32'hAAAA);
    chk("pre_rst.d1", d1_out, 32'h5555);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle("post_rst", acc);
    chk("post_rst.ready", ready_out, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_demux_1x16
